// File: rtl/mult_iter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mult_iter_pkg                                                         |
// | Shared constants, FSM state type and overflow helper for mult_iter.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package mult_iter_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The product fits in WIDTH signed bits only when its top WIDTH+1 bits agree.
    function automatic logic product_overflows(input logic [2*WIDTH-1:0] p);
        logic [WIDTH:0] hi;
        hi = p[2*WIDTH-1:WIDTH-1];
        return !((&hi) || !(|hi));
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_step.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | booth_step                                                            |
// | One combinational radix-2 Booth iteration on {acc, q, q-1}.           |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module booth_step
    import mult_iter_pkg::*;
(
    input  logic [2*WIDTH-1:0] acc_q,
    input  logic               q_m1,
    input  logic [WIDTH-1:0]   mcand,
    output logic [2*WIDTH-1:0] acc_q_next,
    output logic               q_m1_next
);

    logic [WIDTH:0] w_acc_ext;
    logic [WIDTH:0] w_mcand_ext;
    logic [WIDTH:0] w_sum;

    always_comb begin
        // One guard bit keeps +/- 2^31 partial sums exact before the shift.
        w_acc_ext   = {acc_q[2*WIDTH-1], acc_q[2*WIDTH-1:WIDTH]};
        w_mcand_ext = {mcand[WIDTH-1], mcand};
        unique case ({acc_q[0], q_m1})
            2'b01:   w_sum = w_acc_ext + w_mcand_ext;
            2'b10:   w_sum = w_acc_ext - w_mcand_ext;
            default: w_sum = w_acc_ext;
        endcase
        acc_q_next = {w_sum, acc_q[WIDTH-1:1]};
        q_m1_next  = acc_q[0];
    end

endmodule
`default_nettype wire

// File: rtl/mult_iter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mult_iter                                                             |
// | Iterative 32x32 signed Booth multiplier, one bit per clock.           |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module mult_iter
    import mult_iter_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    output logic             ready,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc_q;
    logic               r_q_m1;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_result;
    logic               r_exception;
    logic [2*WIDTH-1:0] w_acc_q_next;
    logic               w_q_m1_next;
    logic               w_last_step;

    booth_step u_booth_step (
        .acc_q      (r_acc_q),
        .q_m1       (r_q_m1),
        .mcand      (r_mcand),
        .acc_q_next (w_acc_q_next),
        .q_m1_next  (w_q_m1_next)
    );

    assign w_last_step = (r_cnt == CNT_W'(ITER - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        ready          = 1'b0;
        data_resultRDY = 1'b0;
        unique case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (ctrl_MULT) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last_step) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                data_resultRDY = 1'b1;
                w_state_next   = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt       <= '0;
            r_acc_q     <= '0;
            r_q_m1      <= 1'b0;
            r_mcand     <= '0;
            r_result    <= '0;
            r_exception <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (ctrl_MULT) begin
                        r_mcand <= data_operandA;
                        r_acc_q <= {{WIDTH{1'b0}}, data_operandB};
                        r_q_m1  <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_acc_q <= w_acc_q_next;
                    r_q_m1  <= w_q_m1_next;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    // Results are captured on the same edge that enters DONE.
                    if (w_last_step) begin
                        r_result    <= w_acc_q_next[WIDTH-1:0];
                        r_exception <= product_overflows(w_acc_q_next);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exception;

endmodule
`default_nettype wire

// File: tb/tb_mult_iter.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mult_iter                                                          |
// | Self-checking bench: behavioural product model plus directed pins.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_mult_iter;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ready;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int assertions = 0;
    int failures   = 0;

    mult_iter dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ready          (ready),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a start in idle yields the signed product 33 edges later.
    int          remaining   = 0;
    longint      prod        = 0;
    logic [31:0] exp_result  = '0;
    logic        exp_exc     = 1'b0;
    bit          model_valid = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            remaining   = 0;
            exp_result  = '0;
            exp_exc     = 1'b0;
            model_valid = 1'b1;
        end else if (remaining == 0) begin
            if (ctrl_MULT) begin
                prod      = longint'($signed(data_operandA)) * longint'($signed(data_operandB));
                remaining = 33;
            end
        end else begin
            remaining--;
            if (remaining == 1) begin
                exp_result = prod[31:0];
                exp_exc    = (longint'($signed(prod[31:0])) != prod);
            end
        end
    end

    always @(negedge clock) begin
        if (model_valid) begin
            check("ready",          ready,          (remaining == 0));
            check("resultRDY",      data_resultRDY, (remaining == 1));
            check("result",         data_result,    exp_result);
            check("exception",      data_exception, exp_exc);
        end
    end

    task automatic do_start(input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        @(posedge clock); #1;
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Waits for the result pulse, counting cycles after the start edge.
    task automatic wait_rdy(input int first_cycle, input bit noise, output int cyc);
        cyc = first_cycle;
        while (data_resultRDY !== 1'b1 && cyc < 40) begin
            if (noise) begin
                ctrl_MULT     = 1'($urandom_range(0, 1));
                data_operandA = $urandom;
                data_operandB = $urandom;
            end
            @(posedge clock); #1;
            cyc++;
        end
        ctrl_MULT = 1'b0;
        check("latency", 64'(cyc), 64'd33);
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit_res, input logic lit_exc);
        int cyc;
        do_start(a, b);
        wait_rdy(1, 1'b0, cyc);
        check({name, "_result"},    data_result,    lit_res);
        check({name, "_exception"}, data_exception, lit_exc);
        check({name, "_model"},     exp_result,     lit_res);
        @(posedge clock); #1;
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [6];
        specials = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000,
                     32'h7FFF_FFFF, 32'h0000_0001, 32'h0001_0000};
        unique case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($signed($urandom_range(0, 200)) - 100);
            2:       return specials[$urandom_range(0, 5)];
            default: return 32'($urandom_range(0, 32'hFFFF)) << $urandom_range(0, 16);
        endcase
    endfunction

    initial begin
        int cyc;
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready",  ready,          1'b1);
        check("rst_result", data_result,    32'h0);
        check("rst_exc",    data_exception, 1'b0);
        check("rst_rdy",    data_resultRDY, 1'b0);
        reset = 1'b0;

        run_op("3x4",    32'd3,          32'd4,          32'h0000_000C, 1'b0);
        run_op("m7x6",   32'hFFFF_FFF9,  32'd6,          32'hFFFF_FFD6, 1'b0);
        run_op("ovf16",  32'h0001_0000,  32'h0001_0000,  32'h0000_0000, 1'b1);
        run_op("minxm1", 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1'b1);
        run_op("minmin", 32'h8000_0000,  32'h8000_0000,  32'h0000_0000, 1'b1);
        run_op("m1xmin", 32'hFFFF_FFFF,  32'h8000_0000,  32'h8000_0000, 1'b1);

        // Start ignored while busy.
        do_start(32'd5, 32'd5);
        repeat (9) begin @(posedge clock); #1; end
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        @(posedge clock); #1;
        ctrl_MULT     = 1'b0;
        wait_rdy(11, 1'b0, cyc);
        check("busy_ignore_result", data_result, 32'd25);
        @(posedge clock); #1;

        // Reset aborts an in-flight operation.
        do_start(32'd2, 32'd3);
        repeat (9) begin @(posedge clock); #1; end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort_ready",  ready,          1'b1);
        check("abort_result", data_result,    32'h0);
        check("abort_rdy",    data_resultRDY, 1'b0);
        repeat (40) begin @(posedge clock); #1; end
        run_op("2x3", 32'd2, 32'd3, 32'd6, 1'b0);

        // Reset wins over a simultaneous start.
        reset         = 1'b1;
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd7;
        data_operandB = 32'd7;
        @(posedge clock); #1;
        reset     = 1'b0;
        ctrl_MULT = 1'b0;
        check("rst_prio_ready", ready, 1'b1);
        @(posedge clock); #1;

        // Randomized operations with busy-time noise and back-to-back issue.
        for (int i = 0; i < 30; i++) begin
            do_start(pick_operand(), pick_operand());
            wait_rdy(1, 1'b1, cyc);
            @(posedge clock); #1;
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) begin @(posedge clock); #1; end
            end
        end

        repeat (2) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mult_iter.md
MULT_ITER -- requirements
Module: mult_iter

Interface
REQ-001 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset, sampled on the rising edge of clock.
REQ-003 SHALL have port data_operandA, input, 32, multiplicand, two's complement; sampled only on an accepted start.
REQ-004 SHALL have port data_operandB, input, 32, multiplier, two's complement; sampled only on an accepted start.
REQ-005 SHALL have port ctrl_MULT, input, 1, start request; accepted only when ready=1.
REQ-006 SHALL have port ready, output, 1, high when in IDLE and able to accept a start.
REQ-007 SHALL have port data_result, output, 32, low 32 bits of the signed product.
REQ-008 SHALL have port data_exception, output, 1, signed-overflow flag for the 32-bit result.
REQ-009 SHALL have port data_resultRDY, output, 1, one-cycle pulse marking a new valid result.

Function
REQ-010 SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-011 IDLE: ctrl_MULT=1 at an edge SHALL latch both operands, clear the 64-bit accumulator, set the iteration counter to 0, and move to RUN.
REQ-012 RUN: each cycle SHALL perform one radix-2 Booth step.
- Examine the multiplier bit pair {q0, q-1}.
- 01: add the multiplicand into the upper 32 bits.
- 10: subtract the multiplicand from the upper 32 bits.
- 00/11: no add or subtract.
- Then arithmetic-right-shift {acc, q, q-1} by 1.
REQ-013 The counter SHALL be 5 bits; after step 31 (counter wraps 31->0) the FSM SHALL move to DONE; exactly 32 RUN cycles.
REQ-014 DONE: data_resultRDY SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-015 Latency: data_resultRDY SHALL be high in the 33rd cycle after the start edge.
REQ-016 data_result and data_exception SHALL update on entry to DONE and hold until the next DONE or reset.
REQ-017 data_exception SHALL be 1 iff bits 63..31 of the 64-bit product are not all equal.
REQ-018 ready SHALL be 1 only in IDLE; ctrl_MULT in RUN or DONE SHALL be ignored, with no operand capture.
REQ-019 Operand input changes after the start edge SHALL NOT affect the in-flight product.
REQ-020 Add/subtract SHALL be 33-bit sign-extended so that -2^31 operands are exact.
REQ-021 Back-to-back: a start is accepted in the IDLE cycle immediately following DONE; minimum issue interval is 34 cycles.

Reset
REQ-022 reset=1 SHALL force IDLE, ready=1, data_result=0, data_exception=0, data_resultRDY=0, counter=0, accumulator=0.
REQ-023 reset asserted mid-RUN or in DONE SHALL abort the operation with no data_resultRDY pulse.
REQ-024 reset SHALL take priority over a simultaneous ctrl_MULT.

Structure
REQ-025 A shared package SHALL hold the constants and state typedef:
- WIDTH=32
- ITER=32
- CNT_W=5
- FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
REQ-026 The combinational Booth step SHALL be one sub-module, booth_step.
- Inputs: 64-bit acc/q, q-1, multiplicand.
- Outputs: next acc/q and next q-1.
- Instantiated once; no other sub-modules.
REQ-027 Control (FSM, counter) and datapath registers SHALL reside in mult_iter.

Verification
REQ-028 A=3, B=4, start -> resultRDY after 33 cycles; result=12, exception=0.
REQ-029 A=-7, B=6 -> result=0xFFFFFFD6 (-42), exception=0.
REQ-030 Overflow cases:
- A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1.
- A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1.
REQ-031 Start with A=5, B=5; reassert ctrl_MULT with A=9, B=9 at cycle 10 -> ignored; result=25; ready=0 cycles 1-33.
REQ-032 Start with A=2, B=3; reset at cycle 10 -> no RDY pulse, result=0, ready=1 next cycle; a new start with A=2, B=3 -> result=6.
